mem_dump_unit: RTL and testbench

- Hardware readback engine for the multicycle CPU's unified byte-addressed RAM.
- Loaders write program and data images into RAM. This block is the opposite direction: after a run it reads a region back and streams it out as little-endian words over a valid/ready interface.
- Sits beside the CPU on a secondary RAM read port. It feeds a scoreboard in simulation or a debug/UART link in hardware.

---
 rtl/mem_dump_pkg.sv | 20 ++
 rtl/mem_dump_unit_word_assembler.sv | 49 ++++
 rtl/mem_dump_unit.sv | 171 +++++++++++++++++
 tb/tb_mem_dump_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dump_pkg.sv
// -----------------------------------------------------------------------------
// mem_dump_pkg
// Shared definitions for the RAM readback engine: default parameter values and
// the state encoding of the dump FSM.
// -----------------------------------------------------------------------------
package mem_dump_pkg;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_WORD_BYTES = 4;
  localparam int DEF_CNT_W      = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    EMIT    = 3'd3,
    DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/mem_dump_unit_word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Builds a little-endian word one byte lane at a time.
// Ports:
//   clk, rst_n  clock / asynchronous active-low reset
//   clr         clear every lane to zero (takes priority over wr_en)
//   wr_en       write wr_byte into lane lane_idx
//   lane_idx    target byte lane (0 = bits [7:0])
//   wr_byte     byte to store
//   word        current assembled word; lanes hold their value otherwise
// -----------------------------------------------------------------------------
module word_assembler #(
  parameter int WORD_BYTES = 4,
  parameter int IDX_W      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        lane_idx,
  input  logic [7:0]              wr_byte,
  output logic [8*WORD_BYTES-1:0] word
);

  for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
    logic [7:0] lane_q;
    logic [7:0] lane_d;

    always_comb begin
      lane_d = lane_q;
      if (clr) begin
        lane_d = '0;
      end else if (wr_en && (lane_idx == IDX_W'(gi))) begin
        lane_d = wr_byte;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_q <= '0;
      end else begin
        lane_q <= lane_d;
      end
    end

    assign word[gi*8 +: 8] = lane_q;
  end

endmodule

// File: rtl/mem_dump_unit.sv
// -----------------------------------------------------------------------------
// mem_dump_unit
// Reads a region of the byte-addressed RAM back out and streams it as
// little-endian words on a valid/ready interface. Two cycles per byte
// (READ strobe, then CAPTURE of the returned byte), then one EMIT per word.
// Ports:
//   clk, rst_n                 clock / asynchronous active-low reset
//   start, start_addr,
//   word_count                 dump request (sampled only while idle)
//   busy, done                 status; done pulses once at completion
//   mem_rd_en, mem_addr,
//   mem_rd_data                RAM read port (data valid the cycle after rd_en)
//   out_valid, out_ready,
//   out_data, out_addr,
//   out_last                   word stream; out_addr = address of byte lane 0
// -----------------------------------------------------------------------------
module mem_dump_unit
  import mem_dump_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int WORD_BYTES = DEF_WORD_BYTES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       start_addr,
  input  logic [CNT_W-1:0]        word_count,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_rd_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [7:0]              mem_rd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*WORD_BYTES-1:0] out_data,
  output logic [ADDR_W-1:0]       out_addr,
  output logic                    out_last
);

  localparam int             IDX_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]  out_addr_q, out_addr_d;
  logic               out_last_q, out_last_d;
  logic               asm_clr, asm_wr;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    out_addr_d  = out_addr_q;
    asm_clr     = 1'b0;
    asm_wr      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            ptr_d       = start_addr;
            remaining_d = word_count;
            idx_d       = '0;
            out_addr_d  = start_addr;
            asm_clr     = 1'b1;
            state_d     = READ;
          end else begin
            state_d = DONE;
          end
        end
      end
      READ: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        // The byte requested in READ is on mem_rd_data now.
        asm_wr = 1'b1;
        ptr_d  = ptr_q + ADDR_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = EMIT;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = READ;
        end
      end
      EMIT: begin
        if (out_ready) begin
          remaining_d = remaining_q - CNT_W'(1);
          idx_d       = '0;
          asm_clr     = 1'b1;
          // ptr already points at the next word's first byte.
          out_addr_d  = ptr_q;
          state_d     = (remaining_q == CNT_W'(1)) ? DONE : READ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered: derive them from the state being entered.
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    mem_rd_en_d = (state_d == READ);
    mem_addr_d  = (state_d == READ) ? ptr_d : mem_addr_q;
    out_valid_d = (state_d == EMIT);
    out_last_d  = (state_d == EMIT) && (remaining_d == CNT_W'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_rd_en_q <= 1'b0;
      mem_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_rd_en_q <= mem_rd_en_d;
      mem_addr_q  <= mem_addr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
    end
  end

  word_assembler #(
    .WORD_BYTES (WORD_BYTES),
    .IDX_W      (IDX_W)
  ) u_word_assembler (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (asm_clr),
    .wr_en    (asm_wr),
    .lane_idx (idx_q),
    .wr_byte  (mem_rd_data),
    .word     (out_data)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_rd_en = mem_rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_mem_dump_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_dump_unit
// Drives directed and randomized dumps against a byte-array RAM model and
// checks every streamed word against words computed from that array.
// -----------------------------------------------------------------------------
module tb_mem_dump_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] start_addr;
  logic [15:0] word_count;
  logic        busy, done, mem_rd_en, out_valid, out_ready, out_last;
  logic [15:0] mem_addr, out_addr;
  logic [7:0]  mem_rd_data;
  logic [31:0] out_data;

  logic [7:0]  ram [65536];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_dump_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_addr  (start_addr),
    .word_count  (word_count),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
    .out_last    (out_last)
  );

  // RAM read port: byte appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a word is the four bytes from its base address, lowest in [7:0].
  function automatic logic [31:0] model_word(input logic [15:0] a);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = ram[16'(a + 16'(b))];
    return w;
  endfunction

  // mode 0: ready high; 1: random ready; 2: ready low for 5 cycles of first EMIT
  task automatic run_dump(input string name, input logic [15:0] sa, input logic [15:0] cnt,
                          input int mode, input bit repulse);
    int k, ndone, done_k, first_valid_k, stall, stable_err, rd_in_emit, bad_seq;
    bit finished, prev_stall, rdy, busy_at_done, busy_after;
    logic [31:0] hold_data;
    logic [15:0] hold_addr;
    logic        hold_last;
    logic [15:0] rd_addrs[$];
    logic [31:0] got_data[$];
    logic [15:0] got_addr[$];
    logic        got_last[$];

    ndone = 0; done_k = -1; first_valid_k = -1; stall = 0; stable_err = 0;
    rd_in_emit = 0; finished = 0; prev_stall = 0; busy_at_done = 0; busy_after = 1;
    hold_data = '0; hold_addr = '0; hold_last = 0;

    @(negedge clk);
    start = 1'b1; start_addr = sa; word_count = cnt; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!finished && k < 3000) begin
      if (done) begin
        ndone++;
        if (ndone == 1) begin done_k = k; busy_at_done = busy; end
      end
      if (ndone > 0 && k == done_k + 1) begin
        busy_after = busy;
        finished = 1;
      end else begin
        if (mem_rd_en) rd_addrs.push_back(mem_addr);
        if (mem_rd_en && out_valid) rd_in_emit++;
        if (out_valid && first_valid_k < 0) first_valid_k = k;
        if (prev_stall && !(out_valid && out_data === hold_data &&
                            out_addr === hold_addr && out_last === hold_last))
          stable_err++;
        case (mode)
          1: rdy = 1'($urandom_range(0, 1));
          2: begin
            rdy = 1'b1;
            if (out_valid && got_data.size() == 0 && stall < 5) begin
              rdy = 1'b0;
              stall++;
            end
          end
          default: rdy = 1'b1;
        endcase
        out_ready = rdy;
        if (out_valid && rdy) begin
          got_data.push_back(out_data);
          got_addr.push_back(out_addr);
          got_last.push_back(out_last);
        end
        prev_stall = out_valid && !rdy;
        hold_data = out_data; hold_addr = out_addr; hold_last = out_last;
        if (repulse && k == 3) begin
          start = 1'b1; start_addr = sa ^ 16'h1234; word_count = cnt + 16'd7;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;

    bad_seq = 0;
    for (int i = 0; i < rd_addrs.size() && i < 4*int'(cnt); i++)
      if (rd_addrs[i] !== 16'(sa + 16'(i))) bad_seq++;

    chk({name, ".finished"}, 64'(finished), 64'd1);
    chk({name, ".done_pulses"}, 64'(ndone), 64'd1);
    chk({name, ".busy_at_done"}, 64'(busy_at_done), 64'd1);
    chk({name, ".busy_after_done"}, 64'(busy_after), 64'd0);
    chk({name, ".first_valid_cycle"}, 64'(first_valid_k), (cnt == 0) ? -64'sd1 : 64'd8);
    if (mode == 0)
      chk({name, ".done_cycle"}, 64'(done_k), 64'(9 * int'(cnt)));
    chk({name, ".word_count"}, 64'(got_data.size()), 64'(cnt));
    chk({name, ".rd_count"}, 64'(rd_addrs.size()), 64'(4 * int'(cnt)));
    chk({name, ".rd_addr_seq"}, 64'(bad_seq), 64'd0);
    chk({name, ".hold_stable"}, 64'(stable_err), 64'd0);
    chk({name, ".rd_during_emit"}, 64'(rd_in_emit), 64'd0);
    for (int i = 0; i < got_data.size() && i < int'(cnt); i++) begin
      logic [15:0] wa;
      wa = 16'(sa + 16'(4 * i));
      chk($sformatf("%s.data[%0d]", name, i), 64'(got_data[i]), 64'(model_word(wa)));
      chk($sformatf("%s.addr[%0d]", name, i), 64'(got_addr[i]), 64'(wa));
      chk($sformatf("%s.last[%0d]", name, i), 64'(got_last[i]), 64'(i == int'(cnt) - 1));
    end
    $display("dump %s: start=%04h count=%0d words=%0d done_cycle=%0d", name, sa, cnt,
             got_data.size(), done_k);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, ".busy"}, 64'(busy), 64'd0);
    chk({name, ".done"}, 64'(done), 64'd0);
    chk({name, ".mem_rd_en"}, 64'(mem_rd_en), 64'd0);
    chk({name, ".out_valid"}, 64'(out_valid), 64'd0);
    chk({name, ".out_last"}, 64'(out_last), 64'd0);
    chk({name, ".mem_addr"}, 64'(mem_addr), 64'd0);
    chk({name, ".out_data"}, 64'(out_data), 64'd0);
    chk({name, ".out_addr"}, 64'(out_addr), 64'd0);
  endtask

  initial begin
    logic [31:0] prog [5];
    int seen_done;

    rst_n = 1'b0; start = 1'b0; start_addr = '0; word_count = '0; out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);

    // Reset state
    repeat (2) @(negedge clk);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // Basic dump
    for (int i = 0; i < 8; i++) ram[i] = 8'h00;
    ram[0] = 8'h01; ram[4] = 8'h02;
    run_dump("basic", 16'h0000, 16'd2, 0, 0);

    // Program region image
    prog[0] = 32'h00100093; prog[1] = 32'h00208113; prog[2] = 32'h002081b3;
    prog[3] = 32'h00312023; prog[4] = 32'h0000006f;
    for (int w = 0; w < 5; w++)
      for (int b = 0; b < 4; b++) ram[16'h0400 + 4*w + b] = prog[w][8*b +: 8];
    run_dump("program", 16'h0400, 16'd5, 0, 0);

    // Backpressure on first word
    run_dump("backpressure", 16'h0400, 16'd2, 2, 0);

    // Zero count
    run_dump("zero", 16'h0100, 16'd0, 0, 0);

    // Start while busy must be ignored
    run_dump("busy_start", 16'h0010, 16'd3, 0, 1);

    // Address wrap
    ram[16'hFFFE] = 8'hAA; ram[16'hFFFF] = 8'hBB; ram[16'h0000] = 8'hCC; ram[16'h0001] = 8'hDD;
    run_dump("wrap", 16'hFFFE, 16'd1, 0, 0);
    chk("wrap.model_word", 64'(model_word(16'hFFFE)), 64'hDDCCBBAA);

    // Randomized dumps with random backpressure
    for (int r = 0; r < 4; r++)
      run_dump($sformatf("rand%0d", r), 16'($urandom), 16'($urandom_range(1, 4)), 1, 0);

    // Reset in the CAPTURE of word 2 of 4
    @(negedge clk);
    start = 1'b1; start_addr = 16'h0200; word_count = 16'd4; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("midreset.busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("midreset");
    seen_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    chk("midreset.no_done", 64'(seen_done), 64'd0);
    $display("midreset: reset applied during second word, done pulses seen=%0d", seen_done);
    run_dump("after_reset", 16'h0200, 16'd4, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
